// File: rtl/pb_event_pkg.sv
// Shared types and constants for the push-button event decoder.
// Holds the FSM state encoding, default timing and the counter-width check.
package pb_event_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESSED  = 3'd1,
    LONG     = 3'd2,
    WAIT2    = 3'd3,
    PRESSED2 = 3'd4
  } pb_state_e;

  localparam int DEF_LONG_TICKS   = 1000;
  localparam int DEF_DCLICK_TICKS = 250;
  localparam int DEF_REPEAT_TICKS = 100;
  localparam int DEF_CNT_W        = 16;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // True when a cnt_w-bit counter can hold every value up to 'ticks'.
  function automatic bit cnt_w_fits(input int cnt_w, input int ticks);
    longint unsigned span;
    if (cnt_w >= 32) return 1'b1;
    span = longint'(1) << cnt_w;
    return span > longint'(ticks);
  endfunction

endpackage

// File: rtl/pb_event_decoder_if.sv
// Button-level input and event-strobe outputs of the push-button event decoder.
// master drives the level and tick; slave is the decoder itself.
interface pb_event_decoder_if;
  logic tick;
  logic pb_level;
  logic press_p;
  logic release_p;
  logic click_p;
  logic dclick_p;
  logic long_p;
  logic repeat_p;
  logic held;

  modport master (
    output tick, pb_level,
    input  press_p, release_p, click_p, dclick_p, long_p, repeat_p, held
  );

  modport slave (
    input  tick, pb_level,
    output press_p, release_p, click_p, dclick_p, long_p, repeat_p, held
  );
endinterface

// File: rtl/pb_edge_detect.sv
// Rise/fall detector on the debounced button level.
// The previous-level register resets to 0, so a level held high through reset reads as a rise.
module pb_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic pb_prev_d;
  logic pb_prev_q;

  always_comb begin
    pb_prev_d = level;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pb_prev_q <= 1'b0;
    end else begin
      pb_prev_q <= pb_prev_d;
    end
  end

  assign rise = level & ~pb_prev_q;
  assign fall = ~level & pb_prev_q;

endmodule

// File: rtl/pb_event_decoder.sv
// Classifies debounced button activity into press/release/click/double-click/long/repeat strobes.
// All strobes and 'held' are registered, so they appear one clk after the causing edge or tick.
module pb_event_decoder
  import pb_event_pkg::*;
#(
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int DCLICK_TICKS = DEF_DCLICK_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  pb_event_decoder_if.slave   bus
);

  if (!cnt_w_fits(CNT_W, max3(LONG_TICKS, DCLICK_TICKS, REPEAT_TICKS))) begin : g_chk_cnt_w
    $error("pb_event_decoder: CNT_W too small for the configured tick limits");
  end
  if (LONG_TICKS < 2 || DCLICK_TICKS < 2 || REPEAT_TICKS < 1) begin : g_chk_ticks
    $error("pb_event_decoder: tick limits out of range");
  end

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

  logic rise;
  logic fall;

  pb_edge_detect u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (bus.pb_level),
    .rise  (rise),
    .fall  (fall)
  );

  pb_state_e        state_d,  state_q;
  logic [CNT_W-1:0] cnt_d,    cnt_q;
  logic             press_d,  press_q;
  logic             rel_d,    rel_q;
  logic             click_d,  click_q;
  logic             dclick_d, dclick_q;
  logic             long_d,   long_q;
  logic             rep_d,    rep_q;
  logic             held_d,   held_q;

  logic [CNT_W-1:0] cnt_inc;
  assign cnt_inc = cnt_q + 1'b1;

  // Edges are checked before ticks in every state, so a coincident tick is dropped
  // and the counter restarts from 0 on the new state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    click_d  = 1'b0;
    dclick_d = 1'b0;
    long_d   = 1'b0;
    rep_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise) begin
          press_d = 1'b1;
          state_d = PRESSED;
        end
      end

      PRESSED: begin
        if (fall) begin
          rel_d   = 1'b1;
          state_d = WAIT2;
          cnt_d   = '0;
        end else if (bus.tick) begin
          if (cnt_q == LONG_LAST) begin
            long_d  = 1'b1;
            state_d = LONG;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      LONG: begin
        if (fall) begin
          rel_d   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (bus.tick) begin
          if (cnt_q == REPEAT_LAST) begin
            rep_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      WAIT2: begin
        if (rise) begin
          press_d = 1'b1;
          state_d = PRESSED2;
          cnt_d   = '0;
        end else if (bus.tick) begin
          if (cnt_q == DCLICK_LAST) begin
            click_d = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      PRESSED2: begin
        if (fall) begin
          rel_d    = 1'b1;
          dclick_d = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else if (bus.tick) begin
          // Held too long to be a double-click: the first press still counts as a click.
          if (cnt_q == LONG_LAST) begin
            click_d = 1'b1;
            long_d  = 1'b1;
            state_d = LONG;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    held_d = (state_d == PRESSED) || (state_d == LONG) || (state_d == PRESSED2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      click_q  <= 1'b0;
      dclick_q <= 1'b0;
      long_q   <= 1'b0;
      rep_q    <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      click_q  <= click_d;
      dclick_q <= dclick_d;
      long_q   <= long_d;
      rep_q    <= rep_d;
      held_q   <= held_d;
    end
  end

  assign bus.press_p   = press_q;
  assign bus.release_p = rel_q;
  assign bus.click_p   = click_q;
  assign bus.dclick_p  = dclick_q;
  assign bus.long_p    = long_q;
  assign bus.repeat_p  = rep_q;
  assign bus.held      = held_q;

endmodule

// File: tb/tb_pb_event_decoder.sv
// Directed bench for pb_event_decoder with LONG=8, DCLICK=4, REPEAT=3 and a tick every 4th clk.
// Outputs are sampled 1 time unit after each rising edge; pulse totals are accumulated per cycle.
module tb_pb_event_decoder;

  logic clk = 1'b0;
  logic rst_n;

  pb_event_decoder_if bus ();

  pb_event_decoder #(
    .LONG_TICKS   (8),
    .DCLICK_TICKS (4),
    .REPEAT_TICKS (3),
    .CNT_W        (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int phase    = 0;
  int n_press, n_rel, n_click, n_dclick, n_long, n_rep;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    n_press = 0; n_rel = 0; n_click = 0; n_dclick = 0; n_long = 0; n_rep = 0;
  endtask

  // One clock: tick is high on every 4th cycle; outputs are tallied after the edge.
  task automatic step();
    bus.tick = (phase == 3);
    @(posedge clk);
    #1;
    phase = (phase + 1) % 4;
    if (bus.press_p   === 1'b1) n_press++;
    if (bus.release_p === 1'b1) n_rel++;
    if (bus.click_p   === 1'b1) n_click++;
    if (bus.dclick_p  === 1'b1) n_dclick++;
    if (bus.long_p    === 1'b1) n_long++;
    if (bus.repeat_p  === 1'b1) n_rep++;
  endtask

  // Returns right after the cycle carrying the n-th tick, so that tick's pulse is visible.
  task automatic run_ticks(input int n);
    int k;
    bit was;
    k = 0;
    while (k < n) begin
      was = (phase == 3);
      step();
      if (was) k++;
    end
  endtask

  // Next step will carry no tick.
  task automatic align();
    while (phase != 0) step();
  endtask

  task automatic set_level(input logic lvl);
    bus.pb_level = lvl;
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_outs"},
             {25'd0, bus.press_p, bus.release_p, bus.click_p, bus.dclick_p,
              bus.long_p, bus.repeat_p, bus.held}, 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.tick     = 1'b0;
    bus.pb_level = 1'b0;
    clear_counts();

    // 1: single click
    step(); step();
    check_all_zero("t1_reset");
    rst_n = 1'b1;
    step(); step();
    check_all_zero("t1_idle");
    align(); clear_counts();
    set_level(1'b1);
    check_eq("t1_press_p", bus.press_p, 1);
    check_eq("t1_held_on", bus.held, 1);
    run_ticks(3);
    check_eq("t1_held_mid", bus.held, 1);
    align();
    set_level(1'b0);
    check_eq("t1_release_p", bus.release_p, 1);
    check_eq("t1_held_off", bus.held, 0);
    run_ticks(3);
    check_eq("t1_no_click_early", n_click, 0);
    run_ticks(1);
    check_eq("t1_click_p", bus.click_p, 1);
    step();
    check_eq("t1_click_one_clk", bus.click_p, 0);
    check_eq("t1_counts", {n_press[7:0], n_rel[7:0], n_dclick[7:0], n_long[3:0], n_rep[3:0]},
             {8'd1, 8'd1, 8'd0, 4'd0, 4'd0});

    // 2: double click
    align(); clear_counts();
    set_level(1'b1);
    run_ticks(2);
    align();
    set_level(1'b0);
    run_ticks(2);
    align();
    set_level(1'b1);
    check_eq("t2_press2_p", bus.press_p, 1);
    run_ticks(2);
    align();
    set_level(1'b0);
    check_eq("t2_release2_p", bus.release_p, 1);
    check_eq("t2_dclick_p", bus.dclick_p, 1);
    run_ticks(6);
    check_eq("t2_press_count", n_press, 2);
    check_eq("t2_no_click", n_click, 0);

    // 3: long hold with repeats
    align(); clear_counts();
    set_level(1'b1);
    run_ticks(7);
    check_eq("t3_no_long_early", n_long, 0);
    run_ticks(1);
    check_eq("t3_long_p", bus.long_p, 1);
    run_ticks(2);
    check_eq("t3_no_rep_early", n_rep, 0);
    run_ticks(1);
    check_eq("t3_repeat_t11", bus.repeat_p, 1);
    run_ticks(9);
    check_eq("t3_repeat_t20", bus.repeat_p, 1);
    check_eq("t3_rep_count", n_rep, 4);
    align();
    set_level(1'b0);
    check_eq("t3_release_p", bus.release_p, 1);
    check_eq("t3_held_off", bus.held, 0);
    run_ticks(6);
    check_eq("t3_no_click", n_click, 0);
    check_eq("t3_no_dclick", n_dclick, 0);

    // 4: click then long hold on the second press
    align(); clear_counts();
    set_level(1'b1);
    run_ticks(1);
    align();
    set_level(1'b0);
    run_ticks(1);
    align();
    set_level(1'b1);
    run_ticks(7);
    check_eq("t4_none_early", n_click + n_long, 0);
    run_ticks(1);
    check_eq("t4_click_long", {bus.click_p, bus.long_p}, 2'b11);
    run_ticks(2);
    check_eq("t4_no_rep_early", n_rep, 0);
    run_ticks(1);
    check_eq("t4_repeat_p", bus.repeat_p, 1);
    align();
    set_level(1'b0);
    check_eq("t4_release_no_dclick", {bus.release_p, bus.dclick_p}, 2'b10);

    // 5: rise coincident with tick, then reset inside the double-click window
    run_ticks(6);
    clear_counts();
    while (phase != 3) step();
    set_level(1'b1);
    check_eq("t5_press_on_tick", bus.press_p, 1);
    run_ticks(7);
    check_eq("t5_tick_ignored", n_long, 0);
    align();
    set_level(1'b0);
    check_eq("t5_release_p", bus.release_p, 1);
    run_ticks(2);
    rst_n = 1'b0;
    step(); step();
    check_all_zero("t5_in_reset");
    rst_n = 1'b1;
    clear_counts();
    run_ticks(8);
    check_eq("t5_no_pulses", n_press + n_rel + n_click + n_dclick + n_long + n_rep, 0);
    check_all_zero("t5_after");

    // 6: level high through reset release
    bus.pb_level = 1'b1;
    rst_n = 1'b0;
    step(); step();
    check_all_zero("t6_in_reset");
    rst_n = 1'b1;
    clear_counts();
    step();
    check_eq("t6_press_p", bus.press_p, 1);
    run_ticks(7);
    check_eq("t6_no_long_early", n_long, 0);
    run_ticks(1);
    check_eq("t6_long_p", bus.long_p, 1);
    check_eq("t6_press_count", n_press, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
